io_bus_master: RTL and testbench
================================

Name: io_bus_master

Overview:
CPU-side initiator for the memory-mapped I/O bus; the counterpart of the I/O responder.
- Accepts single-word read/write requests from the CPU control unit.
- Sequences io_cs/io_rd/io_wr, address and write data onto the bus, and captures read data.
- Terminates the responder's level interrupt (intr) and returns a timed int_ack pulse when the CPU acknowledges.

Parameters:
ADDR_W, 12, I/O byte-address width (word access = 4 bytes, big endian at addr..addr+3)
DATA_W, 32, bus data width
RD_WAIT, 1, cycles io_rd held before read data is sampled (min 1)
ACK_LEN, 2, cycles int_ack is held high (min 1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  request strobe, sampled only in IDLE
cpu_we  in  1  1=write, 0=read; captured with cpu_req
cpu_addr  in  ADDR_W  byte address; captured with cpu_req
cpu_wdata  in  DATA_W  write data; captured with cpu_req
cpu_rdata  out  DATA_W  last read result; holds until next read completes
cpu_busy  out  1  high from the cycle after acceptance through DONE
cpu_done  out  1  one-cycle completion pulse
int_pending  out  1  interrupt request to CPU
cpu_int_ack  in  1  CPU acknowledge strobe
io_cs  out  1  bus chip select
io_rd  out  1  bus read enable
io_wr  out  1  bus write enable
io_addr  out  ADDR_W  bus address
io_wdata  out  DATA_W  bus write data (to responder IO_in)
io_rdata  in  DATA_W  bus read data (from responder IO_out; Z when not selected)
intr  in  1  responder interrupt, level
int_ack  out  1  acknowledge to responder

Behaviour:
Reset (reset=0, asynchronous):
- All outputs 0; cpu_rdata=0.
- Bus FSM to IDLE; interrupt FSM to I_IDLE.
- A transaction in flight is abandoned; no cpu_done.

Bus FSM (registered outputs; io_addr/io_wdata driven only while io_cs=1, else 0):
- IDLE: cpu_req=1 at an edge → capture we/addr/wdata; go to SETUP.
- SETUP (1 cycle): cpu_busy=1, io_cs=1, io_addr valid, io_rd=io_wr=0.
- WRITE (1 cycle): io_cs=1, io_wr=1, io_wdata valid; the responder commits at the closing edge. Then → DONE.
- READ (RD_WAIT cycles, counter): io_cs=1, io_rd=1. At the closing edge of the last cycle, cpu_rdata←io_rdata. Then → DONE.
- DONE (1 cycle): all io_* deasserted, cpu_done=1, cpu_busy=1. Then → IDLE.

Latency and request rules:
- Request accepted at edge N: write gives cpu_done in cycle N+3; read gives cpu_done in cycle N+2+RD_WAIT.
- Back-to-back: a new cpu_req is accepted at the edge ending DONE's successor IDLE cycle. Minimum 4 cycles per write.
- cpu_req while not IDLE: ignored, not queued.
- Operands are frozen after capture; later cpu_* input changes have no effect.

Interrupt FSM (independent of the bus FSM; both may be active in the same cycle):
- I_IDLE: int_pending = intr_s, where intr_s is intr or its synchronized version (see Optional Feature). cpu_int_ack=1 while int_pending=1 → I_ACK. cpu_int_ack while int_pending=0 is ignored.
- I_ACK: int_ack=1 for exactly ACK_LEN cycles (counter), int_pending=0. Then → I_WAIT.
- I_WAIT: int_pending=0 until intr_s is seen low, then → I_IDLE. This prevents re-triggering on a slow intr release.
- An intr edge that occurs during I_ACK or I_WAIT is not lost if intr is still high after dropping low once; otherwise the responder must re-assert it.

Optional Feature:
IO_INT_SYNC_EN
- Defined: intr passes through a 2-flop synchronizer (reset to 0) before use. int_pending rises 2 cycles later than without the feature.
- Undefined: intr is used directly (same-clock responder). int_pending follows intr combinationally in I_IDLE.

Decomposition:
- Package io_bus_pkg: bus FSM state enum (IDLE, SETUP, WRITE, READ, DONE), interrupt state enum (I_IDLE, I_ACK, I_WAIT), default ADDR_W/DATA_W constants.
- Sub-module io_int_handshake: interrupt FSM, ACK_LEN counter, optional synchronizer.
- The bus FSM stays in the top module.

Test Plan:
- Write: cpu_req, we=1, addr=0x010, wdata=0xDEADBEEF → io_wr=1 for exactly one cycle with io_addr=0x010 and io_wdata=0xDEADBEEF; cpu_done in cycle N+3; responder bytes 0x010..0x013 = DE AD BE EF.
- Read-back of 0x010 with RD_WAIT=1 → io_rd=1 for one cycle; cpu_rdata=0xDEADBEEF at cpu_done in cycle N+3. Repeat with RD_WAIT=3 → cpu_done in cycle N+5.
- cpu_req pulsed during READ with addr=0x020 → ignored: no second bus cycle, io_addr never 0x020.
- intr rises → int_pending=1 (same cycle, or +2 cycles with IO_INT_SYNC_EN). Then cpu_int_ack pulse → int_ack=1 for 2 cycles, int_pending=0. intr held high 5 more cycles → int_pending stays 0 until intr low. Re-assert intr → int_pending=1.
- Reset asserted in the middle of READ → io_cs/io_rd/int_ack drop immediately; cpu_rdata=0; no cpu_done. After release, a write to 0x000 completes normally.
- Simultaneous cpu_req (write 0x004=0x12345678) and cpu_int_ack with int_pending=1 → both proceed independently with the correct bus timing and a 2-cycle int_ack.

Source files
------------

// File: rtl/io_bus_pkg.sv
// Shared types and defaults for the I/O bus initiator (io_bus_master).
package io_bus_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
        READ,
        DONE
    } bus_state_e;

    typedef enum logic [1:0] {
        I_IDLE,
        I_ACK,
        I_WAIT
    } int_state_e;

    // Counter width able to hold values 0..n-1 (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_int_handshake.sv
// Interrupt acknowledge handshake between the CPU and the I/O responder.
// Define IO_INT_SYNC_EN to pass intr through a 2-flop synchronizer first.
module io_int_handshake
    import io_bus_pkg::*;
#(
    parameter int unsigned ACK_LEN = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic intr_i,
    input  logic ack_i,
    output logic pending_o,
    output logic int_ack_o
);

    localparam int unsigned CW = cnt_w(ACK_LEN);

    logic intr_s;

`ifdef IO_INT_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= {sync_q[0], intr_i};
    end

    assign intr_s = sync_q[1];
`else
    assign intr_s = intr_i;
`endif

    int_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          int_ack_q, int_ack_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= I_IDLE;
            cnt_q     <= '0;
            int_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            int_ack_q <= int_ack_d;
        end
    end

    // I_WAIT holds off re-triggering until the interrupt line is seen low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            I_IDLE: begin
                if (intr_s && ack_i) begin
                    state_d = I_ACK;
                    cnt_d   = CW'(ACK_LEN - 1);
                end
            end
            I_ACK: begin
                if (cnt_q == '0) state_d = I_WAIT;
                else             cnt_d   = cnt_q - CW'(1);
            end
            I_WAIT: begin
                if (!intr_s) state_d = I_IDLE;
            end
            default: state_d = I_IDLE;
        endcase
        int_ack_d = (state_d == I_ACK);
    end

    assign pending_o = (state_q == I_IDLE) && intr_s;
    assign int_ack_o = int_ack_q;

endmodule

// File: rtl/io_bus_master.sv
// CPU-side initiator for the memory-mapped I/O bus plus interrupt acknowledge.
// Optional IO_INT_SYNC_EN synchronizes intr inside io_int_handshake.
module io_bus_master
    import io_bus_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned RD_WAIT = 1,
    parameter int unsigned ACK_LEN = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic              int_pending,
    input  logic              cpu_int_ack,
    output logic              io_cs,
    output logic              io_rd,
    output logic              io_wr,
    output logic [ADDR_W-1:0] io_addr,
    output logic [DATA_W-1:0] io_wdata,
    input  logic [DATA_W-1:0] io_rdata,
    input  logic              intr,
    output logic              int_ack
);

    localparam int unsigned CW = cnt_w(RD_WAIT);

    bus_state_e    state_q, state_d;
    logic          we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_W-1:0] io_addr_q, io_addr_d;
    logic [DATA_W-1:0] io_wdata_q, io_wdata_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cs_q       <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            io_addr_q  <= '0;
            io_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cs_q       <= cs_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            io_addr_q  <= io_addr_d;
            io_wdata_q <= io_wdata_d;
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    state_d = SETUP;
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                end
            end
            SETUP: begin
                state_d = we_q ? WRITE : READ;
                cnt_d   = CW'(RD_WAIT - 1);
            end
            WRITE: state_d = DONE;
            READ: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    rdata_d = io_rdata;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        cs_d       = (state_d == SETUP) || (state_d == WRITE) || (state_d == READ);
        rd_d       = (state_d == READ);
        wr_d       = (state_d == WRITE);
        io_addr_d  = cs_d ? addr_d  : '0;
        io_wdata_d = cs_d ? wdata_d : '0;
    end

    assign cpu_rdata = rdata_q;
    assign cpu_busy  = busy_q;
    assign cpu_done  = done_q;
    assign io_cs     = cs_q;
    assign io_rd     = rd_q;
    assign io_wr     = wr_q;
    assign io_addr   = io_addr_q;
    assign io_wdata  = io_wdata_q;

    io_int_handshake #(
        .ACK_LEN (ACK_LEN)
    ) u_int (
        .clk_i     (clock),
        .rst_ni    (reset),
        .intr_i    (intr),
        .ack_i     (cpu_int_ack),
        .pending_o (int_pending),
        .int_ack_o (int_ack)
    );

endmodule

// File: tb/tb_io_bus_master.sv
// Scoreboard bench for io_bus_master: dut0 uses RD_WAIT=1, dut3 uses RD_WAIT=3.
module tb_io_bus_master;

`ifdef IO_INT_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        cpu_req0 = 1'b0, cpu_req3 = 1'b0, cpu_we = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_int_ack = 1'b0, intr = 1'b0;

    logic [31:0] rdata0, wdata0, iordata0, rdata3, wdata3, iordata3;
    logic [11:0] addr0, addr3;
    logic busy0, done0, pend0, cs0, rd0, wr0, iack0;
    logic busy3, done3, pend3, cs3, rd3, wr3, iack3;

    io_bus_master #(.ADDR_W(12), .DATA_W(32), .RD_WAIT(1), .ACK_LEN(2)) dut0 (
        .clock(clock), .reset(reset), .cpu_req(cpu_req0), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata0),
        .cpu_busy(busy0), .cpu_done(done0), .int_pending(pend0),
        .cpu_int_ack(cpu_int_ack), .io_cs(cs0), .io_rd(rd0), .io_wr(wr0),
        .io_addr(addr0), .io_wdata(wdata0), .io_rdata(iordata0),
        .intr(intr), .int_ack(iack0));

    io_bus_master #(.ADDR_W(12), .DATA_W(32), .RD_WAIT(3), .ACK_LEN(2)) dut3 (
        .clock(clock), .reset(reset), .cpu_req(cpu_req3), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata3),
        .cpu_busy(busy3), .cpu_done(done3), .int_pending(pend3),
        .cpu_int_ack(cpu_int_ack), .io_cs(cs3), .io_rd(rd3), .io_wr(wr3),
        .io_addr(addr3), .io_wdata(wdata3), .io_rdata(iordata3),
        .intr(intr), .int_ack(iack3));

    // Big-endian byte responder shared by both initiators; only dut0 writes.
    logic [7:0] mem [0:4095];
    always @(posedge clock) begin
        if (cs0 && wr0) begin
            mem[addr0]         <= wdata0[31:24];
            mem[addr0 + 12'd1] <= wdata0[23:16];
            mem[addr0 + 12'd2] <= wdata0[15:8];
            mem[addr0 + 12'd3] <= wdata0[7:0];
        end
    end
    assign iordata0 = (cs0 && rd0) ?
        {mem[addr0], mem[addr0 + 12'd1], mem[addr0 + 12'd2], mem[addr0 + 12'd3]} : '0;
    assign iordata3 = (cs3 && rd3) ?
        {mem[addr3], mem[addr3 + 12'd1], mem[addr3 + 12'd2], mem[addr3 + 12'd3]} : '0;

    int cyc;
    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        bit          rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb0[$], sb3[$];
    logic [43:0] wq0[$];
    logic [11:0] rq0[$], rq3[$];
    exp_t        e0, e3;
    logic [43:0] w0;
    logic [11:0] ra0, ra3;
    int          checks = 0, failures = 0;
    int          rdc0, rdc3;
    bit          prd0, prd3, seen020;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever a DUT presents done or a bus cycle.
    always @(negedge clock) begin
        if (!reset) begin
            prd0 <= 1'b0;
            prd3 <= 1'b0;
        end else begin
            if (done0) begin
                chk("done0_expected", 64'(sb0.size() != 0), 64'(1));
                if (sb0.size() != 0) begin
                    e0 = sb0.pop_front();
                    chk("done0_cycle", 64'(cyc), 64'(e0.cyc));
                    if (e0.rd) chk("cpu_rdata0", 64'(rdata0), 64'(e0.data));
                end
            end
            if (done3) begin
                chk("done3_expected", 64'(sb3.size() != 0), 64'(1));
                if (sb3.size() != 0) begin
                    e3 = sb3.pop_front();
                    chk("done3_cycle", 64'(cyc), 64'(e3.cyc));
                    if (e3.rd) chk("cpu_rdata3", 64'(rdata3), 64'(e3.data));
                end
            end
            if (wr0) begin
                chk("io_wr0_expected", 64'(wq0.size() != 0), 64'(1));
                if (wq0.size() != 0) begin
                    w0 = wq0.pop_front();
                    chk("io_addr0_wr", 64'(addr0), 64'(w0[43:32]));
                    chk("io_wdata0_wr", 64'(wdata0), 64'(w0[31:0]));
                end
            end
            if (rd0 && !prd0) begin
                chk("io_rd0_expected", 64'(rq0.size() != 0), 64'(1));
                if (rq0.size() != 0) begin
                    ra0 = rq0.pop_front();
                    chk("io_addr0_rd", 64'(addr0), 64'(ra0));
                end
            end
            if (rd3 && !prd3) begin
                chk("io_rd3_expected", 64'(rq3.size() != 0), 64'(1));
                if (rq3.size() != 0) begin
                    ra3 = rq3.pop_front();
                    chk("io_addr3_rd", 64'(addr3), 64'(ra3));
                end
            end
            if (rd0) rdc0 <= rdc0 + 1;
            if (rd3) rdc3 <= rdc3 + 1;
            if ((cs0 && addr0 == 12'h020) || (cs3 && addr3 == 12'h020)) seen020 <= 1'b1;
            prd0 <= rd0;
            prd3 <= rd3;
        end
    end

    // Issue one request; latency in edges after acceptance: write 2, read 1+RD_WAIT.
    task automatic issue(input bit unit, input bit we, input logic [11:0] a,
                         input logic [31:0] d, input bit ack, input bit expect_done);
        exp_t e;
        int   lat;
        @(negedge clock);
        cpu_we      = we;
        cpu_addr    = a;
        cpu_wdata   = d;
        cpu_int_ack = ack;
        if (unit) cpu_req3 = 1'b1;
        else      cpu_req0 = 1'b1;
        @(posedge clock);
        #1;
        cpu_req0    = 1'b0;
        cpu_req3    = 1'b0;
        cpu_int_ack = 1'b0;
        cpu_addr    = ~a;
        cpu_wdata   = ~d;
        cpu_we      = ~we;
        lat    = we ? 2 : (1 + (unit ? 3 : 1));
        e.rd   = !we;
        e.data = d;
        e.cyc  = cyc + lat;
        if (unit) begin
            if (expect_done) sb3.push_back(e);
            if (!we) rq3.push_back(a);
        end else begin
            if (expect_done) sb0.push_back(e);
            if (!we) rq0.push_back(a);
            else     wq0.push_back({a, d});
        end
    endtask

    task automatic wait_done(input bit unit);
        for (int i = 0; i < 30; i++) begin
            if ((unit ? sb3.size() : sb0.size()) == 0) break;
            @(negedge clock);
        end
        chk("done_timeout", 64'((unit ? sb3.size() : sb0.size()) == 0), 64'(1));
        @(negedge clock);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clock);
        #1;
        chk("reset_rdata0", 64'(rdata0), 64'(0));
        chk("reset_ctrl0", 64'({busy0, done0, cs0, rd0, wr0, iack0, pend0}), 64'(0));
        chk("reset_bus0", 64'({addr0, wdata0}), 64'(0));
        chk("reset_ctrl3", 64'({busy3, done3, cs3, rd3, wr3, iack3, pend3}), 64'(0));
        @(negedge clock);
        reset = 1'b1;

        // Acknowledge without a pending interrupt is ignored.
        @(negedge clock); cpu_int_ack = 1'b1;
        @(negedge clock); cpu_int_ack = 1'b0;
        chk("ack_ignored", 64'(iack0), 64'(0));

        issue(1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0, 1'b1);
        wait_done(1'b0);
        chk("mem_0x010", 64'({mem[16], mem[17], mem[18], mem[19]}), 64'(32'hDEADBEEF));

        issue(1'b0, 1'b0, 12'h010, 32'hDEADBEEF, 1'b0, 1'b1);
        wait_done(1'b0);

        // RD_WAIT=3 read with a request pulse to 0x020 in the middle of READ.
        issue(1'b1, 1'b0, 12'h010, 32'hDEADBEEF, 1'b0, 1'b1);
        @(negedge clock);
        @(negedge clock);
        cpu_req3 = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h020; cpu_wdata = 32'h55;
        @(negedge clock);
        cpu_req3 = 1'b0;
        wait_done(1'b1);
        repeat (3) @(negedge clock);
        chk("ignored_req_not_queued", 64'(busy3), 64'(0));

        // Interrupt handshake.
        @(negedge clock); intr = 1'b1;
        repeat (SYNC_LAT) @(negedge clock);
        #1 chk("int_pending_rise", 64'(pend0), 64'(1));
        @(negedge clock); cpu_int_ack = 1'b1;
        @(negedge clock); cpu_int_ack = 1'b0;
        chk("int_ack_cycle1", 64'({iack0, pend0}), 64'(2'b10));
        @(negedge clock);
        chk("int_ack_cycle2", 64'({iack0, pend0}), 64'(2'b10));
        @(negedge clock);
        chk("int_ack_end", 64'(iack0), 64'(0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("int_pending_held_low", 64'(pend0), 64'(0));
        end
        intr = 1'b0;
        repeat (SYNC_LAT + 2) @(negedge clock);
        chk("int_pending_after_release", 64'(pend0), 64'(0));
        intr = 1'b1;
        repeat (SYNC_LAT) @(negedge clock);
        #1 chk("int_pending_rearm", 64'(pend0), 64'(1));

        // Bus write and interrupt acknowledge in the same cycle.
        issue(1'b0, 1'b1, 12'h004, 32'h12345678, 1'b1, 1'b1);
        @(negedge clock);
        chk("sim_int_ack1", 64'({iack0, pend0, busy0}), 64'(3'b101));
        @(negedge clock);
        chk("sim_int_ack2", 64'(iack0), 64'(1));
        @(negedge clock);
        chk("sim_int_ack_end", 64'(iack0), 64'(0));
        wait_done(1'b0);
        chk("mem_0x004", 64'({mem[4], mem[5], mem[6], mem[7]}), 64'(32'h12345678));
        intr = 1'b0;
        repeat (SYNC_LAT + 3) @(negedge clock);

        // Reset in the middle of an RD_WAIT=3 read while int_ack is high.
        intr = 1'b1;
        repeat (SYNC_LAT) @(negedge clock);
        issue(1'b1, 1'b0, 12'h010, 32'hDEADBEEF, 1'b1, 1'b0);
        @(negedge clock);
        @(negedge clock);
        #2;
        chk("pre_reset_read", 64'({cs3, rd3, iack0}), 64'(3'b111));
        reset = 1'b0;
        #1;
        chk("reset_drop_bus3", 64'({cs3, rd3, busy3}), 64'(0));
        chk("reset_drop_int_ack", 64'({iack0, iack3}), 64'(0));
        chk("reset_rdata_clear", 64'({rdata0, rdata3}), 64'(0));
        repeat (2) @(negedge clock);
        chk("reset_no_done", 64'({done0, done3}), 64'(0));
        reset = 1'b1;
        intr  = 1'b0;
        repeat (SYNC_LAT + 3) @(negedge clock);

        issue(1'b0, 1'b1, 12'h000, 32'hA5A50001, 1'b0, 1'b1);
        wait_done(1'b0);
        chk("mem_0x000", 64'({mem[0], mem[1], mem[2], mem[3]}), 64'(32'hA5A50001));

        repeat (3) @(negedge clock);
        chk("queues_drained", 64'(sb0.size() + sb3.size() + wq0.size() + rq0.size() + rq3.size()), 64'(0));
        chk("io_rd0_cycles", 64'(rdc0), 64'(1));
        chk("io_rd3_cycles", 64'(rdc3), 64'(4));
        chk("addr_0x020_never_on_bus", 64'(seen020), 64'(0));
        chk("final_idle", 64'({busy0, busy3}), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
